// File: rtl/coin_bank.sv
// Credit stage in front of the coffee-machine FSM: synchronises and edge-detects
// the coin sensors, holds the credit, times the brew and pays change coin by coin.
module coin_bank #(
    parameter int unsigned PRICE       = 300,
    parameter int unsigned MAX_VAL     = 9900,
    parameter int unsigned BREW_CYCLES = 8,
    parameter int unsigned RETURN_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coin_100_raw,
    input  logic        coin_500_raw,
    input  logic        coffee_make,
    input  logic        coin_return,
    output logic        coin,
    output logic [15:0] coin_val,
    output logic        coffee_out,
    output logic        ret_100,
    output logic        ret_500,
    output logic        coin_reject
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BREW   = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    localparam logic [15:0] PRICE_16   = 16'(PRICE);
    localparam logic [16:0] PRICE_17   = 17'(PRICE);
    localparam logic [16:0] MAX_17     = 17'(MAX_VAL);
    localparam logic [7:0]  BREW_LOAD  = 8'(BREW_CYCLES - 1);
    localparam logic [7:0]  GAP_LOAD   = 8'(RETURN_GAP - 1);

    logic [2:0]  sync100_r;
    logic [2:0]  sync500_r;
    logic        make_d_r;
    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [15:0] coin_val_r;
    logic        coin_r;
    logic        coffee_out_r;
    logic        ret_100_r;
    logic        ret_500_r;
    logic        coin_reject_r;

    logic        e100_s;
    logic        e500_s;
    logic        any_edge_s;
    logic        make_rise_s;
    logic        deduct_s;
    logic [16:0] add_s;
    logic [16:0] net_s;
    logic [15:0] after_deduct_s;
    logic        accept_s;
    logic        reject_s;
    logic [15:0] credit_val_s;
    logic [15:0] eject_val_s;
    logic        eject_100_s;
    logic        eject_500_s;

    // Sensor synchronisers; bit 1 is the synchronised level, bit 2 its delayed copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync100_r <= 3'b000;
            sync500_r <= 3'b000;
        end else begin
            sync100_r <= {sync100_r[1:0], coin_100_raw};
            sync500_r <= {sync500_r[1:0], coin_500_raw};
        end
    end

    assign e100_s      = sync100_r[1] & ~sync100_r[2];
    assign e500_s      = sync500_r[1] & ~sync500_r[2];
    assign any_edge_s  = e100_s | e500_s;
    assign make_rise_s = coffee_make & ~make_d_r;

    // Credit arithmetic; the limit check sees the value net of a same-cycle deduction.
    always_comb begin
        deduct_s       = (state_r == ST_IDLE) && make_rise_s && (coin_val_r >= PRICE_16);
        add_s          = (e100_s ? 17'd100 : 17'd0) + (e500_s ? 17'd500 : 17'd0);
        net_s          = {1'b0, coin_val_r} + add_s - (deduct_s ? PRICE_17 : 17'd0);
        after_deduct_s = deduct_s ? (coin_val_r - PRICE_16) : coin_val_r;
        accept_s       = any_edge_s && (state_r != ST_RETURN) && (net_s <= MAX_17);
        reject_s       = any_edge_s && !accept_s;
        if (accept_s) begin
            credit_val_s = net_s[15:0];
        end else begin
            credit_val_s = after_deduct_s;
        end
    end

    // Largest coin that still fits in the remaining credit; sub-100 residue is dropped.
    always_comb begin
        eject_val_s = 16'd0;
        eject_100_s = 1'b0;
        eject_500_s = 1'b0;
        if (coin_val_r >= 16'd500) begin
            eject_val_s = coin_val_r - 16'd500;
            eject_500_s = 1'b1;
        end else if (coin_val_r >= 16'd100) begin
            eject_val_s = coin_val_r - 16'd100;
            eject_100_s = 1'b1;
        end else begin
            eject_val_s = 16'd0;
        end
    end

    // Controller FSM with registered credit and output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            make_d_r      <= 1'b0;
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            coin_val_r    <= 16'd0;
            coin_r        <= 1'b0;
            coffee_out_r  <= 1'b0;
            ret_100_r     <= 1'b0;
            ret_500_r     <= 1'b0;
            coin_reject_r <= 1'b0;
        end else begin
            make_d_r      <= coffee_make;
            coin_r        <= accept_s;
            coin_reject_r <= reject_s;
            coffee_out_r  <= 1'b0;
            ret_100_r     <= 1'b0;
            ret_500_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    coin_val_r <= credit_val_s;
                    if (deduct_s) begin
                        state_r <= ST_BREW;
                        cnt_r   <= BREW_LOAD;
                    end else if (coin_return && (coin_val_r != 16'd0)) begin
                        state_r <= ST_RETURN;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_BREW: begin
                    coin_val_r <= credit_val_s;
                    if (cnt_r == 8'd0) begin
                        coffee_out_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_RETURN: begin
                    if (cnt_r == 8'd0) begin
                        coin_val_r <= eject_val_s;
                        ret_100_r  <= eject_100_s;
                        ret_500_r  <= eject_500_s;
                        cnt_r      <= GAP_LOAD;
                        if (eject_val_s == 16'd0) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_RETURN;
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 8'd0;
                    coin_val_r <= 16'd0;
                end
            endcase
        end
    end

    assign coin        = coin_r;
    assign coin_val    = coin_val_r;
    assign coffee_out  = coffee_out_r;
    assign ret_100     = ret_100_r;
    assign ret_500     = ret_500_r;
    assign coin_reject = coin_reject_r;

endmodule
